// File: rtl/pla_sweep_checker.sv
// Exhaustive self-test engine for combinational decode blocks: walks every
// IN_W-bit input vector (binary or Gray order), compares DUT against reference.
module pla_sweep_checker #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 8,
  parameter int SETTLE_W = 4,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                gray_mode,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [IN_W-1:0]     stim,
  input  logic [OUT_W-1:0]    dut_f,
  input  logic [OUT_W-1:0]    ref_f,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                first_fail_valid,
  output logic [IN_W-1:0]     first_fail_vec,
  output logic [OUT_W-1:0]    first_fail_dut,
  output logic [OUT_W-1:0]    first_fail_ref
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     index_q, index_d;
  logic [IN_W-1:0]     stim_q, stim_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                gray_q, gray_d;
  logic [ERRCNT_W-1:0] err_q, err_d;
  logic                ffv_q, ffv_d;
  logic [IN_W-1:0]     ffvec_q, ffvec_d;
  logic [OUT_W-1:0]    ffdut_q, ffdut_d;
  logic [OUT_W-1:0]    ffref_q, ffref_d;

  logic [IN_W-1:0]     index_nxt;
  logic                last_vec;
  logic                mismatch;

  assign index_nxt = index_q + 1'b1;
  assign last_vec  = (index_q == {IN_W{1'b1}});
  assign mismatch  = (dut_f != ref_f);

  function automatic logic [IN_W-1:0] encode(input logic [IN_W-1:0] v, input logic gray);
    return gray ? (v ^ (v >> 1)) : v;
  endfunction

  always_comb begin
    // NOTE: every next-state variable takes its held value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    state_d  = state_q;
    index_d  = index_q;
    stim_d   = stim_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    gray_d   = gray_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    ffdut_d  = ffdut_q;
    ffref_d  = ffref_q;

    if (abort) begin
      // Results stay readable after an abort; only the sweep itself is dropped.
      state_d = S_IDLE;
      index_d = '0;
      stim_d  = '0;
      cnt_d   = '0;
    end else if (start && state_q != S_SETTLE) begin
      state_d  = S_SETTLE;
      index_d  = '0;
      stim_d   = '0;
      cnt_d    = settle_cycles;
      settle_d = settle_cycles;
      gray_d   = gray_mode;
      err_d    = '0;
      ffv_d    = 1'b0;
      ffvec_d  = '0;
      ffdut_d  = '0;
      ffref_d  = '0;
    end else if (state_q == S_SETTLE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        if (mismatch) begin
          if (err_q != {ERRCNT_W{1'b1}}) err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = stim_q;
            ffdut_d = dut_f;
            ffref_d = ref_f;
          end
        end
        if (last_vec) begin
          // Stim keeps the final vector; index never wraps into a second pass.
          state_d = S_DONE;
        end else begin
          index_d = index_nxt;
          stim_d  = encode(index_nxt, gray_q);
          cnt_d   = settle_q;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      stim_q   <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      gray_q   <= 1'b0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      ffdut_q  <= '0;
      ffref_q  <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      stim_q   <= stim_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      gray_q   <= gray_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      ffdut_q  <= ffdut_d;
      ffref_q  <= ffref_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = (state_q == S_SETTLE);
  assign done             = (state_q == S_DONE);
  assign pass             = done && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_dut   = ffdut_q;
  assign first_fail_ref   = ffref_q;

endmodule

// File: doc/pla_sweep_checker.md
Name: pla_sweep_checker

Overview:
- Sequential, parametrised on-chip self-test engine for combinational decode blocks such as the C64 PLA.
- Walks every input vector of an IN_W-bit combinational DUT in binary or Gray-code order, waits a programmable settle time, and compares the DUT outputs against a reference implementation.
- Counts mismatches and captures the first failing vector.
- Sits beside a PLA-type design inside chip_top so exhaustive equivalence runs on silicon, not only in simulation.

Parameters:
IN_W, 16, width of stimulus vector; sweep length is 2^IN_W vectors
OUT_W, 8, width of compared output vectors
SETTLE_W, 4, width of settle-cycle setting
ERRCNT_W, 16, width of saturating mismatch counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; honoured only in IDLE or DONE
abort  input  1  stop sweep, return to IDLE; results retained
gray_mode  input  1  0 = binary ascending order, 1 = reflected Gray order; sampled at start
settle_cycles  input  SETTLE_W  extra wait cycles per vector; sampled at start
stim  output  IN_W  registered stimulus driven to DUT and reference
dut_f  input  OUT_W  DUT outputs
ref_f  input  OUT_W  reference outputs
busy  output  1  high while sweeping
done  output  1  high from sweep completion until next start or abort
pass  output  1  done && err_count == 0
err_count  output  ERRCNT_W  mismatching vectors, saturating at all-ones
first_fail_valid  output  1  a mismatch has been captured this run
first_fail_vec  output  IN_W  stim of first mismatch
first_fail_dut  output  OUT_W  dut_f at first mismatch
first_fail_ref  output  OUT_W  ref_f at first mismatch

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous active-low.
- Reset values: all outputs 0, state IDLE, internal index 0.
- States:
  - IDLE -> SETTLE on start.
  - SETTLE -> SETTLE while settle counter > 0.
  - SETTLE -> SETTLE at the next vector once the counter is 0 and the vector is not last.
  - SETTLE -> DONE on the last vector.
  - DONE -> SETTLE on start.
  - Any state -> IDLE on abort; abort has priority over start.
- On start:
  - index := 0, stim := 0.
  - Settle counter := settle_cycles; settle_cycles and gray_mode are latched.
  - err_count, first_fail_* and done are cleared.
  - busy := 1.
- Per vector:
  - stim holds for settle_cycles+1 cycles.
  - On the edge where the counter is 0, dut_f/ref_f are compared and index increments.
  - On that same edge, stim := next vector and the counter is reloaded.
- Stimulus encoding: stim = index in binary mode; stim = index ^ (index >> 1) in Gray mode, so exactly one stim bit changes per step.
- Total busy time is 2^IN_W × (settle_cycles+1) cycles. busy falls and done rises on the edge that compares the last vector (index all-ones). index does not wrap into a second pass.
- Mismatch (dut_f != ref_f at compare edge):
  - err_count increments unless already all-ones.
  - If first_fail_valid is 0: capture stim/dut_f/ref_f and set first_fail_valid.
- Final-vector mismatch is counted before done asserts; pass reflects it in the same cycle.
- Abort:
  - busy := 0, done stays 0, stim := 0.
  - err_count and first_fail_* hold their values for readout.
- start while busy is ignored; start and abort in the same cycle → abort wins.
- settle_cycles changes during a run have no effect.
- rst_n low at any time immediately clears everything to reset values, including a run in progress.
- Compare path uses no combinational output loop: stim is a flop output; dut_f/ref_f are sampled only at compare edges.

Test Plan (IN_W=4, OUT_W=2, ERRCNT_W=3 unless stated):
- Binary mode, settle_cycles=0, ref_f=dut_f=stim[1:0] → stim sequence 0..15 one per cycle; busy exactly 16 cycles; done=1, pass=1, err_count=0, first_fail_valid=0.
- Fault injection: dut_f = ref_f ^ 2'b01 when stim==5 → err_count=1, first_fail_vec=5, first_fail_dut/ref differ in bit 0, pass=0.
- Gray mode, settle_cycles=0 → stim sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8; Hamming distance 1 between successive values; done after 16 cycles.
- settle_cycles=3, dut_f wrong only during the first 2 cycles after each stim change → busy 64 cycles, err_count=0, pass=1, proving comparison occurs on the 4th cycle.
- All vectors mismatch → err_count saturates at 7, first_fail_vec=0, pass=0; then a new start clears results, and a clean rerun gives pass=1.
- Abort at vector 9 with 2 errors logged → busy=0, done=0, stim=0, err_count=2 retained. In a separate run, rst_n pulsed low mid-run → all outputs 0 asynchronously; the next start runs normally.
